// File: rtl/per2apb_pkg.sv
// Shared types and constants for the per-to-APB3 bridge.
package per2apb_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  localparam logic [DATA_WIDTH-1:0] TIMEOUT_RDATA = 32'hBADA_BADA;

endpackage

// File: rtl/per2apb_bridge.sv
// Per-interconnect slave issuing one APB3 master transfer per accepted request,
// with a bounded PREADY wait that answers with an error instead of hanging.
module per2apb_bridge
  import per2apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      per_slave_req_i,
  input  logic [31:0]               per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [DATA_WIDTH-1:0]     per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [ID_WIDTH-1:0]       per_slave_id_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [DATA_WIDTH-1:0]     per_slave_r_rdata_o,
  output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0]     pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [DATA_WIDTH-1:0]     prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    load_req;
  logic                    opc_d;
  logic [DATA_WIDTH-1:0]   rdata_d;

  // APB3 has no strobes and only the low address bits reach the bus.
  logic unused_bits;
  assign unused_bits = ^{per_slave_be_i, per_slave_add_i};

  // Grant only from IDLE, and never while reset is held so no request is lost.
  assign per_slave_gnt_o = (state_q == ST_IDLE) & per_slave_req_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_req = 1'b0;
    opc_d    = per_slave_r_opc_o;
    rdata_d  = per_slave_r_rdata_o;
    unique case (state_q)
      ST_IDLE: begin
        if (per_slave_gnt_o) begin
          load_req = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A ready in the expiry cycle still completes normally.
        if (pready_i) begin
          rdata_d = pwrite_o ? '0 : prdata_i;
          opc_d   = pslverr_i;
          state_d = ST_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TMO_LAST))) begin
          rdata_d = TIMEOUT_RDATA;
          opc_d   = OPC_ERR;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they only move on clock edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psel_o              <= 1'b0;
      penable_o           <= 1'b0;
      pwrite_o            <= 1'b0;
      paddr_o             <= '0;
      pwdata_o            <= '0;
      per_slave_r_valid_o <= 1'b0;
      per_slave_r_opc_o   <= OPC_OK;
      per_slave_r_rdata_o <= '0;
      per_slave_r_id_o    <= '0;
    end else begin
      psel_o              <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_o           <= (state_d == ST_ACCESS);
      per_slave_r_valid_o <= (state_d == ST_RESP);
      per_slave_r_opc_o   <= opc_d;
      per_slave_r_rdata_o <= rdata_d;
      if (load_req) begin
        paddr_o          <= per_slave_add_i[APB_ADDR_WIDTH-1:0];
        pwrite_o         <= per_slave_we_i;
        pwdata_o         <= per_slave_wdata_i;
        per_slave_r_id_o <= per_slave_id_i;
      end
    end
  end

endmodule

// File: tb/tb_per2apb_bridge.sv
// Directed bench for per2apb_bridge with a short timeout so expiry is reachable.
module tb_per2apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] add;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [7:0]  id;
  logic        gnt;
  logic        r_valid;
  logic        r_opc;
  logic [31:0] r_rdata;
  logic [7:0]  r_id;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  per2apb_bridge #(
    .APB_ADDR_WIDTH(32),
    .ID_WIDTH      (8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .per_slave_req_i    (req),
    .per_slave_add_i    (add),
    .per_slave_we_i     (we),
    .per_slave_wdata_i  (wdata),
    .per_slave_be_i     (be),
    .per_slave_id_i     (id),
    .per_slave_gnt_o    (gnt),
    .per_slave_r_valid_o(r_valid),
    .per_slave_r_opc_o  (r_opc),
    .per_slave_r_rdata_o(r_rdata),
    .per_slave_r_id_o   (r_id),
    .paddr_o            (paddr),
    .pwdata_o           (pwdata),
    .pwrite_o           (pwrite),
    .psel_o             (psel),
    .penable_o          (penable),
    .prdata_i           (prdata),
    .pready_i           (pready),
    .pslverr_i          (pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One transaction: cycle 0 is the grant cycle; pready is raised only in cycle rdy_cyc.
  task automatic run(input string tag, input logic [31:0] a, input logic w,
                     input logic [31:0] wd, input logic [7:0] tid, input int rdy_cyc,
                     input logic err, input logic [31:0] prd, input int exp_cyc,
                     input logic [31:0] exp_rdata, input logic exp_opc);
    int got;
    nxt();
    rst = 1'b0; req = 1'b1; add = a; we = w; wdata = wd; be = 4'hF; id = tid;
    pready = 1'b0; pslverr = 1'b0; prdata = prd;
    settle();
    check({tag, "_gnt"}, 32'(gnt), 32'd1);
    check({tag, "_idle_psel"}, {30'd0, psel, penable}, 32'd0);
    check({tag, "_idle_rvalid"}, 32'(r_valid), 32'd0);
    check({tag, "_rdata_hold"}, r_rdata, last_rdata);
    got = 0;
    for (int c = 1; c <= 16 && got == 0; c++) begin
      nxt();
      req = 1'b0; id = 8'hEE; wdata = 32'hDEAD_0000; add = 32'h0;
      pready = (c == rdy_cyc); pslverr = err && (c == rdy_cyc);
      settle();
      if (r_valid) begin
        got = 1;
        check({tag, "_rcycle"}, 32'(c), 32'(exp_cyc));
        check({tag, "_rdata"}, r_rdata, exp_rdata);
        check({tag, "_opc"}, 32'(r_opc), 32'(exp_opc));
        check({tag, "_rid"}, 32'(r_id), 32'(tid));
        check({tag, "_resp_psel"}, {30'd0, psel, penable}, 32'd0);
      end else begin
        check({tag, "_psel"}, {30'd0, psel, penable}, {30'd0, 1'b1, c >= 2});
        check({tag, "_paddr"}, paddr, a);
        check({tag, "_pwdata"}, pwdata, wd);
        check({tag, "_pwrite_gnt"}, {30'd0, pwrite, gnt}, {30'd0, w, 1'b0});
      end
    end
    if (got == 0) check({tag, "_no_rvalid"}, 32'd0, 32'd1);
    pready = 1'b0; pslverr = 1'b0;
    last_rdata = exp_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] ids [3];
    int         gc [3];
    int         rc [3];
    logic [7:0] rid [3];
    int         ng;
    int         nr;

    rst = 1'b1; req = 1'b1; add = 32'h1A10_0000; we = 1'b1; wdata = 32'hFFFF_FFFF;
    be = 4'hF; id = 8'hFF; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    nxt(); nxt();
    settle();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_apb", {29'd0, psel, penable, pwrite}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_resp", {30'd0, r_valid, r_opc}, 32'd0);
    check("rst_rdata", r_rdata, 32'd0);
    check("rst_rid", 32'(r_id), 32'd0);
    last_rdata = 32'h0;

    run("rd0", 32'h1A10_0004, 1'b0, 32'h0, 8'h5A, 2, 1'b0, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0);
    run("wr3", 32'h1A10_0008, 1'b1, 32'h1234_5678, 8'h21, 5, 1'b0, 32'h5555_AAAA, 6, 32'h0, 1'b0);
    run("rd_err", 32'h1A10_0010, 1'b0, 32'h0, 8'h33, 2, 1'b1, 32'h0BAD_0001, 3, 32'h0BAD_0001, 1'b1);
    run("rd_after_err", 32'h1A10_0014, 1'b0, 32'h0, 8'h34, 3, 1'b0, 32'h0000_1234, 4, 32'h0000_1234, 1'b0);
    run("tmo", 32'h1A10_0020, 1'b0, 32'h0, 8'h44, 99, 1'b0, 32'h7777_7777, 6, 32'hBADA_BADA, 1'b1);
    run("tmo_rdy", 32'h1A10_0024, 1'b0, 32'h0, 8'h45, 5, 1'b0, 32'h8888_1111, 6, 32'h8888_1111, 1'b0);
    run("tmo_err", 32'h1A10_0028, 1'b1, 32'hA5A5_A5A5, 8'h46, 99, 1'b0, 32'h0, 6, 32'hBADA_BADA, 1'b1);

    // Back-to-back with req held high: grants every 4 cycles, IDs echoed in order.
    ids[0] = 8'h11; ids[1] = 8'h22; ids[2] = 8'h33;
    ng = 0; nr = 0;
    for (int c = 0; c < 16; c++) begin
      nxt();
      req = (ng < 3); id = (ng < 3) ? ids[ng] : 8'h00; we = 1'b0; add = 32'h1A10_0030;
      pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
      settle();
      if (gnt) begin
        if (ng < 3) gc[ng] = c;
        ng++;
      end
      if (r_valid) begin
        if (nr < 3) begin
          rc[nr] = c;
          rid[nr] = r_id;
        end
        nr++;
      end
    end
    check("b2b_ngnt", 32'(ng), 32'd3);
    check("b2b_nrsp", 32'(nr), 32'd3);
    if (ng == 3 && nr == 3) begin
      check("b2b_gnt0", 32'(gc[0]), 32'd0);
      check("b2b_gnt1", 32'(gc[1]), 32'd4);
      check("b2b_gnt2", 32'(gc[2]), 32'd8);
      check("b2b_rv0", 32'(rc[0]), 32'd3);
      check("b2b_rv2", 32'(rc[2]), 32'd11);
      check("b2b_id0", 32'(rid[0]), 32'h11);
      check("b2b_id1", 32'(rid[1]), 32'h22);
      check("b2b_id2", 32'(rid[2]), 32'h33);
    end
    req = 1'b0; pready = 1'b0;
    last_rdata = 32'h0;

    // Reset during ACCESS: transfer aborted, no response, next request served.
    nxt();
    req = 1'b1; add = 32'h1A10_000C; we = 1'b0; id = 8'h77;
    settle();
    check("mid_gnt", 32'(gnt), 32'd1);
    nxt();
    req = 1'b0;
    settle();
    check("mid_setup", {30'd0, psel, penable}, 32'd2);
    nxt();
    settle();
    check("mid_access", {30'd0, psel, penable}, 32'd3);
    nxt();
    rst = 1'b1;
    settle();
    check("mid_rst_rvalid", 32'(r_valid), 32'd0);
    last_rdata = 32'h0;
    run("rst_recover", 32'h1A10_0040, 1'b0, 32'h0, 8'h78, 2, 1'b0, 32'h600D_600D, 3, 32'h600D_600D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
